// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, H/V position counters, sync/DE/coordinate decode and line/frame strobes.
// All outputs registered; decode comes from next-state counters so it tracks Hcnt/Vcnt with zero skew; EN=0 freezes the raster.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CLK_DIV  = 4,
    parameter int CNT_W    = 11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    output logic             PIX_CE,
    output logic [CNT_W-1:0] Hcnt,
    output logic [CNT_W-1:0] Vcnt,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ACT   = (HS_POL != 0);
    localparam logic             VS_ACT   = (VS_POL != 0);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_ce_q, pix_ce_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             advance;

    always_comb begin
        div_cnt_d = div_cnt_q;
        pix_ce_d  = 1'b0;
        if (EN) begin
            pix_ce_d  = (div_cnt_q == DIV_LAST);
            div_cnt_d = pix_ce_d ? '0 : div_cnt_q + DIV_ONE;
        end
    end

    // Gating with EN keeps the raster frozen even if EN drops during a PIX_CE cycle.
    assign advance = EN && pix_ce_q;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (advance) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
            end else begin
                hcnt_d = hcnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        de_d          = (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
        x_d           = de_d ? hcnt_d : '0;
        y_d           = de_d ? vcnt_d : '0;
        hsync_d       = ((hcnt_d >= HS_BEG_C) && (hcnt_d < HS_END_C)) ? HS_ACT : ~HS_ACT;
        vsync_d       = ((vcnt_d >= VS_BEG_C) && (vcnt_d < VS_END_C)) ? VS_ACT : ~VS_ACT;
        line_start_d  = advance && (hcnt_d == '0);
        frame_start_d = line_start_d && (vcnt_d == '0);
    end

    // Reset parks the raster on the last back-porch pixel so the first advance lands on (0,0).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt_q     <= '0;
            pix_ce_q      <= 1'b0;
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_ce_q      <= pix_ce_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_CE      = pix_ce_q;
    assign Hcnt        = hcnt_q;
    assign Vcnt        = vcnt_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 15x8 raster (HSYNC active-high at Hcnt 10..12, VSYNC active-low at Vcnt 5..6, 3 CLK per pixel).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN;
    logic       PIX_CE;
    logic [4:0] Hcnt, Vcnt, X, Y;
    logic       HSYNC, VSYNC, DE, LINE_START, FRAME_START;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(3), .CNT_W(5)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PIX_CE(PIX_CE),
        .Hcnt(Hcnt), .Vcnt(Vcnt), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
        .X(X), .Y(Y), .LINE_START(LINE_START), .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0] h, v, x, y;
        logic       hs, vs, de, ls, fs;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mh, mv;

    // Expected outputs for a raster position; boundaries hand-computed for the 15x8 geometry.
    function automatic pix_t ref_pix(input int h, input int v);
        pix_t p;
        bit   act;
        act  = (h < 8) && (v < 4);
        p.h  = 5'(h);
        p.v  = 5'(v);
        p.de = act;
        p.x  = act ? 5'(h) : 5'd0;
        p.y  = act ? 5'(v) : 5'd0;
        p.hs = (h >= 10) && (h <= 12);
        p.vs = !((v >= 5) && (v <= 6));
        p.ls = (h == 0);
        p.fs = (h == 0) && (v == 0);
        return p;
    endfunction

    function automatic pix_t cur();
        return {Hcnt, Vcnt, X, Y, HSYNC, VSYNC, DE, LINE_START, FRAME_START};
    endfunction

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            exp_q.push_back(ref_pix(mh, mv));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge CLK);
            #2;
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pixels still expected after %0d CLK, required 0", exp_q.size(), c);
            exp_q.delete();
        end
    endtask

    // Monitor: every PIX_CE&EN cycle yields a new pixel on the following cycle.
    logic tick_prev = 1'b0;
    always @(negedge CLK) begin
        pix_t e;
        if (tick_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_extra: unexpected advance to h=%0d v=%0d", Hcnt, Vcnt);
            end else begin
                e = exp_q.pop_front();
                if (cur() !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got %h (h=%0d v=%0d), expected %h (h=%0d v=%0d)",
                             cur(), Hcnt, Vcnt, e, e.h, e.v);
                end
            end
        end
        tick_prev = RST_N && PIX_CE && EN;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int viol;
        RST_N = 1'b0;
        EN    = 1'b0;
        mh    = 14;
        mv    = 7;
        repeat (3) @(posedge CLK);
        #2;
        check("reset_hcnt", Hcnt, 14);
        check("reset_vcnt", Vcnt, 7);
        check("reset_de", DE, 0);
        check("reset_xy", {X, Y}, 0);
        check("reset_hsync", HSYNC, 0);
        check("reset_vsync", VSYNC, 1);
        check("reset_pix_ce", PIX_CE, 0);
        check("reset_strobes", {LINE_START, FRAME_START}, 0);

        // Two full frames plus 35 pixels, landing on (5,2).
        push_pixels(276);
        RST_N = 1'b1;
        EN    = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check("first_pix_ce", PIX_CE, 1);
        check("first_pix_ce_hcnt", Hcnt, 14);
        cnt = 0;
        repeat (30) begin
            @(posedge CLK);
            #2;
            if (PIX_CE) cnt++;
        end
        check("pix_ce_rate_30clk", cnt, 10);
        drain(276 * 3 + 20);

        EN   = 1'b0;
        viol = 0;
        repeat (20) begin
            @(posedge CLK);
            #2;
            if (PIX_CE || LINE_START || FRAME_START || Hcnt != 5'd5) viol++;
        end
        check("pause_violations", viol, 0);
        check("pause_hv", {Hcnt, Vcnt}, {5'd5, 5'd2});
        check("pause_de_xy", {DE, X, Y}, {1'b1, 5'd5, 5'd2});
        check("pause_syncs", {HSYNC, VSYNC}, 2'b01);
        EN = 1'b1;

        // Resume to (11,3), inside HSYNC.
        push_pixels(21);
        drain(21 * 3 + 20);
        check("hsync_before_reset", HSYNC, 1);
        RST_N = 1'b0;
        #1;
        check("async_reset_hsync", HSYNC, 0);
        check("async_reset_hv", {Hcnt, Vcnt}, {5'd14, 5'd7});
        check("async_reset_de", DE, 0);
        mh = 14;
        mv = 7;
        repeat (4) @(posedge CLK);
        #2;
        push_pixels(122);
        RST_N = 1'b1;
        drain(122 * 3 + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 1056x628 H/V counter block.
- Adds programmable porches and sync, sync polarity, display enable, and pixel coordinates.
- Adds frame/line start strobes, a run enable, and an internal pixel clock-enable in place of a derived clock.
- Sits between the system clock and the pixel/framebuffer fetch logic.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels, >=1)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines, >=1)
- HS_POL, 1, 1 = HSYNC active-high, 0 = active-low
- VS_POL, 1, 1 = VSYNC active-high, 0 = active-low
- CLK_DIV, 4, CLK cycles per pixel (>=1)
- CNT_W, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset
- EN  in  1  timing run enable
- PIX_CE  out  1  pixel clock-enable, one CLK wide
- Hcnt  out  CNT_W  horizontal position 0..H_TOTAL-1
- Vcnt  out  CNT_W  vertical position 0..V_TOTAL-1
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  display enable (active region)
- X  out  CNT_W  active pixel column, 0 outside active region
- Y  out  CNT_W  active pixel row, 0 outside active region
- LINE_START  out  1  strobe: Hcnt became 0
- FRAME_START  out  1  strobe: Hcnt and Vcnt became 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line layout: active, then FP, then sync, then BP. Frame layout is the same.
- Divider: div_cnt counts 0..CLK_DIV-1 while EN=1.
  - PIX_CE is registered and is 1 for exactly one CLK in every CLK_DIV.
  - With CLK_DIV=1, PIX_CE is constantly 1 while EN=1.
- Counter advance happens on the CLK edge that ends a PIX_CE=1 cycle.
  - Hcnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, Vcnt increments and wraps V_TOTAL-1 -> 0.
- Decode outputs (HSYNC, VSYNC, DE, X, Y) are registered from next-state counter values.
  - They always describe the current Hcnt/Vcnt, with zero skew.
- DE = (Hcnt < H_ACTIVE) && (Vcnt < V_ACTIVE).
- HSYNC is active when H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level.
- VSYNC is active when V_ACTIVE+V_FP <= Vcnt < V_ACTIVE+V_FP+V_SYNC. It is line-aligned and changes only when Hcnt wraps.
- Active level of HSYNC is HS_POL; active level of VSYNC is VS_POL. Inactive level is the inverse.
- X = DE ? Hcnt : 0; Y = DE ? Vcnt : 0.
- Strobes:
  - LINE_START is high for the single CLK immediately after the edge on which Hcnt becomes 0.
  - FRAME_START is high for the single CLK immediately after the edge on which both Hcnt and Vcnt become 0; LINE_START is also high in that cycle.
- Reset (RST_N=0), applied immediately:
  - div_cnt=0, PIX_CE=0, Hcnt=H_TOTAL-1, Vcnt=V_TOTAL-1.
  - DE=0, X=Y=0, HSYNC=~HS_POL, VSYNC=~VS_POL, strobes 0.
  - These values are consistent with the last back-porch pixel.
  - After release, the first counter advance lands on (0,0) with DE=1 and FRAME_START=1.
- Reset mid-frame: counters jump to the reset position with no partial pulse; the next frame starts cleanly.
- EN=0:
  - div_cnt, counters and decoded outputs hold.
  - PIX_CE=0 and both strobes are 0.
  - Resuming EN continues from the held position; div_cnt is not cleared.
- No arithmetic overflow: counters compare against the constants H_TOTAL-1 and V_TOTAL-1 before incrementing.

Test Plan:
- Reset release, defaults, EN=1 -> PIX_CE every 4th CLK. First advance gives Hcnt=0, Vcnt=0, DE=1, FRAME_START=1 and LINE_START=1 for one CLK. HSYNC=VSYNC=0 before that.
- Defaults, one line -> DE high for pixels 0..799; HSYNC high for Hcnt 840..967; LINE_START period = 1056 pixel ticks = 4224 CLK.
- Full frame -> VSYNC high for Vcnt 601..604. FRAME_START period = 1056*628 = 663168 pixel ticks. X/Y read 799/599 at the last active pixel and 0 in blanking.
- HS_POL=0, VS_POL=0, CLK_DIV=1 -> syncs idle high and pulse low at the same positions; PIX_CE constantly 1; Hcnt advances every CLK.
- EN low for 50 CLK at Hcnt=500, Vcnt=10 -> all outputs frozen, PIX_CE=0. After EN returns, Hcnt continues at 501 with no lost or duplicated pixel.
- RST_N pulsed low mid-HSYNC (Hcnt=900) -> HSYNC goes inactive asynchronously, Hcnt=1055, Vcnt=627. After release, the next frame starts at (0,0) with FRAME_START.
